dmem_arbiter: RTL and testbench

- Shares the four byte-lane data memory banks between two requesters: the CPU execute stage (port 0) and an external loader/debug master (port 1).
- Memory reads are combinational and writes happen at posedge clk. Byte write enables are active-low, matching the existing data memory banks.
- Arbitration is round-robin. The external master may lock the memory for a bounded burst.
- The block raises cpu_stall whenever the CPU is waiting for a grant; the pc register must hold while cpu_stall=1.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_arb2.sv | 72 +++++++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port ids, byte-lane
// write-enable patterns (active-low) and the grant vector encoding.
package dmem_arbiter_pkg;

  // Port identifiers, also used as the value of rid and last_win.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  // Active-low byte-lane write enables as seen by the memory banks.
  localparam logic [3:0] WREN_NONE = 4'b1111;
  localparam logic [3:0] WREN_WORD = 4'b0000;
  localparam logic [3:0] WREN_HALF = 4'b1100;
  localparam logic [3:0] WREN_BYTE = 4'b1110;

  // Grant vector: bit 0 = cpu, bit 1 = ext; never both set.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_EXT  = 2'b10;

  // Port id owning a grant vector (only meaningful when a grant is present).
  function automatic logic gnt_port(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a bounded burst lock for the ext port.
// The ext port may keep winning ties while ext_lock is held, but only for
// MAX_BURST consecutive grants while the cpu is waiting.
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rstd,
  input  logic       cpu_req,
  input  logic       ext_req,
  input  logic       ext_lock,
  output logic [1:0] gnt
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             last_win_r;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [1:0]       gnt_s;
  logic             lock_ok_s;

  assign lock_ok_s = ext_lock && (last_win_r == PORT_EXT) && (burst_cnt_r < MAX_CNT);

  // Grant decision for the current cycle; suppressed entirely during reset.
  always_comb begin
    gnt_s = GNT_NONE;
    if (rstd) begin
      gnt_s = GNT_NONE;
    end else if (cpu_req && !ext_req) begin
      gnt_s = GNT_CPU;
    end else if (!cpu_req && ext_req) begin
      gnt_s = GNT_EXT;
    end else if (cpu_req && ext_req) begin
      if (lock_ok_s) begin
        gnt_s = GNT_EXT;
      end else if (last_win_r == PORT_EXT) begin
        gnt_s = GNT_CPU;
      end else begin
        gnt_s = GNT_EXT;
      end
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Track the last winner and how long the cpu has been held off by ext.
  always_ff @(posedge clk) begin
    if (rstd) begin
      last_win_r  <= PORT_EXT;
      burst_cnt_r <= '0;
    end else if (gnt_s == GNT_EXT) begin
      last_win_r <= PORT_EXT;
      if (cpu_req && (burst_cnt_r < MAX_CNT)) begin
        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end else if (gnt_s == GNT_CPU) begin
      last_win_r  <= PORT_CPU;
      burst_cnt_r <= '0;
    end else begin
      last_win_r  <= last_win_r;
      burst_cnt_r <= '0;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the four byte-lane banks between the cpu
// execute stage and an external loader/debug master. Grants are decided
// combinationally; read data is registered one cycle after the grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic [3:0]        ext_wren,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              rvalid,
  output logic              rid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        gnt_s;
  logic              rvalid_r;
  logic              rid_r;
  logic [DATA_W-1:0] rdata_r;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_arb2 (
    .clk      (clk),
    .rstd     (rstd),
    .cpu_req  (cpu_req),
    .ext_req  (ext_req),
    .ext_lock (ext_lock),
    .gnt      (gnt_s)
  );

  assign cpu_gnt   = gnt_s[0];
  assign ext_gnt   = gnt_s[1];
  assign cpu_stall = cpu_req & ~gnt_s[0];

  // Route the granted port onto the banks; idle bus never writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = WREN_NONE;
    case (gnt_s)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_wren;
      end
      GNT_EXT: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_wren  = ext_wren;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = WREN_NONE;
      end
    endcase
  end

  // Capture pre-write bank data and its owner on every grant.
  always_ff @(posedge clk) begin
    if (rstd) begin
      rvalid_r <= 1'b0;
      rid_r    <= 1'b0;
      rdata_r  <= '0;
    end else if (gnt_s != GNT_NONE) begin
      rvalid_r <= 1'b1;
      rid_r    <= gnt_port(gnt_s);
      rdata_r  <= mem_rdata;
    end else begin
      rvalid_r <= 1'b0;
      rid_r    <= rid_r;
      rdata_r  <= rdata_r;
    end
  end

  assign rvalid = rvalid_r;
  assign rid    = rid_r;
  assign rdata  = rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, compared against a behavioural arbiter/memory model.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rstd;
  logic        cpu_req, ext_req, ext_lock;
  logic [3:0]  cpu_wren, ext_wren;
  logic [7:0]  cpu_addr, ext_addr;
  logic [31:0] cpu_wdata, ext_wdata;
  logic        cpu_gnt, cpu_stall, ext_gnt;
  logic        rvalid, rid;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren;
  logic [31:0] mem_rdata;

  // Bench-side memory banks (the environment the arbiter drives)
  logic [31:0] bmem [256];
  assign mem_rdata = bmem[mem_addr];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!mem_wren[i]) bmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rstd(rstd),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_wren(ext_wren), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .rvalid(rvalid), .rid(rid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] ref_mem   [256];
  bit          ref_known [256];
  string       prev_winner = "ext";  // "cpu" / "ext"
  int          ext_streak  = 0;      // ext grants in a row while cpu waits
  logic        exp_rvalid = 1'b0, exp_rid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_rdata_known = 1'b1;
  string       last_grant;           // "cpu" / "ext" / "none" of the last cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which port should win under the arbitration rules
  function automatic string pick(input logic cr, input logic er, input logic lk);
    if (cr && !er) return "cpu";
    if (er && !cr) return "ext";
    if (!cr && !er) return "none";
    if (lk && prev_winner == "ext" && ext_streak < MAXB) return "ext";
    return (prev_winner == "ext") ? "cpu" : "ext";
  endfunction

  // One clock: check combinational grant/mux, advance model, check read path
  task automatic cycle();
    string       w;
    logic [3:0]  ewren;
    logic [7:0]  eaddr;
    logic [31:0] ewdata;
    #2;
    w = rstd ? "none" : pick(cpu_req, ext_req, ext_lock);
    last_grant = w;
    ewren  = (w == "cpu") ? cpu_wren  : (w == "ext") ? ext_wren  : 4'b1111;
    eaddr  = (w == "cpu") ? cpu_addr  : (w == "ext") ? ext_addr  : 8'h00;
    ewdata = (w == "cpu") ? cpu_wdata : (w == "ext") ? ext_wdata : 32'h0;
    chk("cpu_gnt",   {31'h0, cpu_gnt},   {31'h0, w == "cpu"});
    chk("ext_gnt",   {31'h0, ext_gnt},   {31'h0, w == "ext"});
    chk("cpu_stall", {31'h0, cpu_stall}, {31'h0, cpu_req && (w != "cpu")});
    chk("mem_wren",  {28'h0, mem_wren},  {28'h0, ewren});
    if (w != "none") chk("mem_addr", {24'h0, mem_addr}, {24'h0, eaddr});

    if (rstd) begin
      exp_rvalid = 1'b0; exp_rid = 1'b0; exp_rdata = 32'h0; exp_rdata_known = 1'b1;
      prev_winner = "ext"; ext_streak = 0;
    end else if (w == "none") begin
      exp_rvalid = 1'b0;
      ext_streak = 0;
    end else begin
      exp_rvalid = 1'b1;
      exp_rid = (w == "ext");
      exp_rdata = ref_mem[eaddr];
      exp_rdata_known = ref_known[eaddr];
      for (int i = 0; i < 4; i++)
        if (!ewren[i]) ref_mem[eaddr][8*i +: 8] = ewdata[8*i +: 8];
      if (ewren == 4'b0000) ref_known[eaddr] = 1'b1;
      if (w == "ext" && cpu_req) ext_streak = (ext_streak < MAXB) ? ext_streak + 1 : MAXB;
      else if (w == "cpu") ext_streak = 0;
      prev_winner = w;
    end

    @(posedge clk);
    #1;
    chk("rvalid", {31'h0, rvalid}, {31'h0, exp_rvalid});
    chk("rid",    {31'h0, rid},    {31'h0, exp_rid});
    if (exp_rdata_known) chk("rdata", rdata, exp_rdata);
  endtask

  int stalls;
  string rr_exp [4];

  initial begin
    for (int a = 0; a < 256; a++) ref_known[a] = 1'b0;
    rstd = 1'b1; cpu_req = 1'b1; ext_req = 1'b1; ext_lock = 1'b0;
    cpu_wren = 4'b1111; ext_wren = 4'b1111; cpu_addr = 8'h0; ext_addr = 8'h0;
    cpu_wdata = 32'h0; ext_wdata = 32'h0;
    @(posedge clk); #1;

    // Reset held two cycles with both ports requesting
    repeat (2) cycle();
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);

    // Round-robin: cpu first after reset, then alternating
    rstd = 1'b0;
    rr_exp[0] = "cpu"; rr_exp[1] = "ext"; rr_exp[2] = "cpu"; rr_exp[3] = "ext";
    for (int i = 0; i < 4; i++) begin
      cpu_wren = 4'b0000; cpu_addr = 8'h20 + 8'(i); cpu_wdata = $urandom;
      ext_wren = 4'b0000; ext_addr = 8'h30 + 8'(i); ext_wdata = $urandom;
      cycle();
      chk("rr_order", {31'h0, last_grant == rr_exp[i]}, 32'h1);
    end

    // CPU alone: write then read back
    ext_req = 1'b0;
    cpu_wren = 4'b0000; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
    cycle();
    chk("cpu_write_gnt", {31'h0, last_grant == "cpu"}, 32'h1);
    cpu_wren = 4'b1111;
    cycle();
    chk("cpu_read_rdata", rdata, 32'hDEADBEEF);
    chk("cpu_read_rid", {31'h0, rid}, 32'h0);

    // Preload addresses 0..15; address 5 gets a known pattern
    for (int a = 0; a < 16; a++) begin
      cpu_wren = 4'b0000; cpu_addr = 8'(a);
      cpu_wdata = (a == 5) ? 32'hAABBCCDD : $urandom;
      cycle();
    end

    // Ext single-byte write onto known content, then cpu read
    cpu_req = 1'b0; ext_req = 1'b1;
    ext_wren = 4'b1110; ext_addr = 8'h05; ext_wdata = 32'h11223344;
    cycle();
    cpu_req = 1'b1; ext_req = 1'b0; cpu_wren = 4'b1111; cpu_addr = 8'h05;
    cycle();
    chk("byte_lane", rdata, 32'hAABBCC44);

    // Burst lock: ext alone first, then both with lock held
    cpu_req = 1'b0; ext_req = 1'b1; ext_lock = 1'b1; ext_wren = 4'b1111; ext_addr = 8'h03;
    cycle();
    cpu_req = 1'b1; cpu_addr = 8'h04;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_grant != "cpu") stalls++;
    end
    chk("burst_stalls", 32'(stalls), 32'd4);
    chk("burst_release", {31'h0, last_grant == "cpu"}, 32'h1);

    // Reset mid-burst, then the cpu must win the first tie
    repeat (2) cycle();
    rstd = 1'b1;
    cycle();
    rstd = 1'b0; ext_lock = 1'b0;
    cycle();
    chk("post_reset_tie", {31'h0, last_grant == "cpu"}, 32'h1);

    // Randomized traffic over the preloaded window
    for (int i = 0; i < 400; i++) begin
      rstd      = ($urandom_range(0, 99) < 3);
      cpu_req   = ($urandom_range(0, 9) < 7);
      ext_req   = ($urandom_range(0, 9) < 7);
      ext_lock  = $urandom_range(0, 1);
      cpu_addr  = 8'($urandom_range(0, 15));
      ext_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      ext_wdata = $urandom;
      case ($urandom_range(0, 4))
        0: cpu_wren = 4'b0000; 1: cpu_wren = 4'b1100; 2: cpu_wren = 4'b1110;
        default: cpu_wren = 4'b1111;
      endcase
      case ($urandom_range(0, 4))
        0: ext_wren = 4'b0000; 1: ext_wren = 4'b1100; 2: ext_wren = 4'b1110;
        default: ext_wren = 4'b1111;
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
